// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus controller handshake.
// The master side is the fetch unit, and the slave side is memory and the controller.
interface fetch_unit_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 23
);
  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_data;
  logic [INST_W-1:0] code;
  logic              start;
  logic              inc_pc;
  logic              branch;

  modport master (
    output mem_req, mem_addr, code, start,
    input  mem_ack, mem_data, inc_pc, branch
  );

  modport slave (
    input  mem_req, mem_addr, code, start,
    output mem_ack, mem_data, inc_pc, branch
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one instruction per step over req/ack,
// issues it to the controller and advances or branches on completion.
module fetch_unit #(
  parameter int         PC_W    = 8,
  parameter int         INST_W  = 23,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  fetch_unit_if.master    bus,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]      state;
  logic [PC_W-1:0] next_pc;
  logic [2:0]      fetched_op;

  assign fetched_op = bus.mem_data[INST_W-1 -: 3];

  // Target PC at EXEC completion; also the address of the following fetch.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (bus.branch) begin
      next_pc = bus.code[PC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      bus.code     <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.start    <= 1'b0;
    end else begin
      bus.start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state        <= S_FETCH;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc;
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            bus.code    <= bus.mem_data;
            bus.mem_req <= 1'b0;
            // start is registered, so raising it here makes it visible during ISSUE.
            if (fetched_op == HALT_OP) begin
              state <= S_HALTED;
            end else begin
              state     <= S_ISSUE;
              bus.start <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.inc_pc) begin
            pc <= next_pc;
            if (run) begin
              state        <= S_FETCH;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= next_pc;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state       <= S_IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = (state != S_IDLE) && (state != S_HALTED);
  assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench drives memory acks and controller pulses by hand.
// Inputs change on the falling edge, and outputs are sampled there as well.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fetch_unit_if #(.PC_W(8), .INST_W(23)) bus ();

  fetch_unit #(
    .PC_W   (8),
    .INST_W (23),
    .HALT_OP(3'b111)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .bus   (bus.master),
    .pc    (pc),
    .busy  (busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered on a falling edge while in FETCH. Returns on the falling edge after the ack (ISSUE or HALTED).
  task automatic do_fetch(input string tag, input logic [7:0] a, input logic [22:0] d,
                          input int unsigned waits, input bit is_halt);
    bit stable = 1'b1;
    for (int unsigned i = 0; i < waits; i++) begin
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === a && bus.start === 1'b0)) stable = 1'b0;
      step();
    end
    check({tag, "_wait_stable"}, 32'(stable), 32'd1);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
    bus.mem_ack  = 1'b1;
    bus.mem_data = d;
    step();
    bus.mem_ack  = 1'b0;
    bus.mem_data = 23'($urandom);
    check({tag, "_code"}, 32'(bus.code), 32'(d));
    check({tag, "_start"}, 32'(bus.start), 32'(!is_halt));
    check({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'(is_halt));
  endtask

  // ISSUE -> EXEC; start must have been a single pulse.
  task automatic to_exec(input string tag);
    step();
    check({tag, "_one_start"}, 32'(bus.start), 32'd0);
  endtask

  // One-cycle inc_pc in EXEC.
  task automatic complete(input bit br);
    bus.inc_pc = 1'b1;
    bus.branch = br;
    step();
    bus.inc_pc = 1'b0;
    bus.branch = 1'b0;
  endtask

  initial begin
    bit idle_ok;
    rst          = 1'b1;
    run          = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    bus.inc_pc   = 1'b0;
    bus.branch   = 1'b0;

    // 1: reset state and idle hold, reset mid-fetch, then a late ack
    step();
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_code", 32'(bus.code), 32'd0);
    check("rst_busy", 32'({busy, halted, bus.start}), 32'd0);
    rst = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mem_req !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_hold", 32'(idle_ok), 32'd1);
    run = 1'b1;
    step();
    check("fetch_req", 32'(bus.mem_req), 32'd1);
    check("fetch_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(bus.mem_req), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_code", 32'(bus.code), 32'd0);
    check("midrst_start", 32'(bus.start), 32'd0);
    step();
    rst          = 1'b0;
    run          = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = 23'h7ABCDE;
    step();
    bus.mem_ack = 1'b0;
    step();
    check("late_ack_code", 32'(bus.code), 32'd0);
    check("late_ack_state", 32'({busy, halted, bus.mem_req}), 32'd0);

    // 2: linear fetch with a zero-wait ack; inc_pc in ISSUE is ignored
    run = 1'b1;
    step();
    do_fetch("lin", 8'h00, 23'h012345, 0, 1'b0);
    bus.inc_pc = 1'b1;
    step();
    bus.inc_pc = 1'b0;
    check("issue_inc_ign", 32'(pc), 32'd0);
    check("lin_one_start", 32'(bus.start), 32'd0);
    complete(1'b0);
    check("lin_pc", 32'(pc), 32'd1);
    check("lin_next_addr", 32'(bus.mem_addr), 32'd1);

    // 3: branch, with branch alone (no inc_pc) ignored
    do_fetch("br", 8'h01, 23'h000140, 0, 1'b0);
    to_exec("br");
    bus.branch = 1'b1;
    step();
    bus.branch = 1'b0;
    check("br_no_inc", 32'(pc), 32'd1);
    complete(1'b1);
    check("br_pc", 32'(pc), 32'h40);
    check("br_next_addr", 32'(bus.mem_addr), 32'h40);

    // 4: three wait states, then branch to 0xFF and wrap around
    do_fetch("wait", 8'h40, 23'h0123FF, 3, 1'b0);
    to_exec("wait");
    complete(1'b1);
    check("wrap_pre", 32'(pc), 32'hFF);
    do_fetch("wrap", 8'hFF, 23'h000001, 0, 1'b0);
    to_exec("wrap");
    complete(1'b0);
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_addr", 32'(bus.mem_addr), 32'h00);

    // 5: branch to 2 and fetch the HALT opcode, which sticks until reset
    do_fetch("to2", 8'h00, 23'h000002, 0, 1'b0);
    to_exec("to2");
    complete(1'b1);
    do_fetch("halt", 8'h02, 23'h700000, 0, 1'b1);
    check("halt_busy", 32'(busy), 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run = i[0];
      bus.mem_ack = 1'b1;
      step();
      if (halted !== 1'b1 || bus.mem_req !== 1'b0 || bus.start !== 1'b0) idle_ok = 1'b0;
    end
    bus.mem_ack = 1'b0;
    check("halt_sticky", 32'(idle_ok), 32'd1);
    check("halt_code", 32'(bus.code), 32'h700000);
    run = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("halt_rst", 32'({halted, busy}), 32'd0);
    check("halt_rst_pc", 32'(pc), 32'd0);

    // 6: stop while in EXEC, then stray ack and inc_pc in IDLE
    run = 1'b1;
    step();
    do_fetch("stop", 8'h00, 23'h000010, 0, 1'b0);
    to_exec("stop");
    run = 1'b0;
    step();
    check("stop_exec_busy", 32'(busy), 32'd1);
    complete(1'b0);
    check("stop_pc", 32'(pc), 32'd1);
    check("stop_idle", 32'({busy, bus.mem_req}), 32'd0);
    bus.mem_ack  = 1'b1;
    bus.mem_data = 23'h055555;
    bus.inc_pc   = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    bus.inc_pc  = 1'b0;
    step();
    check("stray_code", 32'(bus.code), 32'h000010);
    check("stray_pc", 32'(pc), 32'd1);
    check("stray_req", 32'(bus.mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
